// File: rtl/mul_array_pipe_if.sv
// Beat-level bus of mul_array_pipe: operand buses in, product beat out, plus mode/occupancy status.
// master is the producer/consumer side, slave is the multiplier array.
interface mul_array_pipe_if #(
  parameter int F          = 4,
  parameter int I          = 4,
  parameter int DW         = 16,
  parameter int PW         = 32,
  parameter int SPARSE_LAT = 6,
  parameter int DENSE_LAT  = 1
);
  localparam int MAXLAT = (SPARSE_LAT > DENSE_LAT) ? SPARSE_LAT : DENSE_LAT;
  localparam int OCCW   = $clog2(MAXLAT + 1);

  logic                mode_sparse;
  logic                in_valid;
  logic                in_ready;
  logic [I*DW-1:0]     ia_data;
  logic [I-1:0]        ia_valid;
  logic [F*DW-1:0]     wt_data;
  logic [F-1:0]        wt_valid;
  logic [F*I*DW-1:0]   dn_ia_data;
  logic [F*I-1:0]      dn_ia_valid;
  logic [DW-1:0]       dn_wt_data;
  logic                dn_wt_valid;
  logic                partial_c_in;
  logic                out_valid;
  logic                out_ready;
  logic [F*I*PW-1:0]   out_data;
  logic [F*I-1:0]      out_lane_valid;
  logic                out_partial_c;
  logic                cur_mode;
  logic [OCCW-1:0]     occupancy;

  modport master (
    output mode_sparse, in_valid, ia_data, ia_valid, wt_data, wt_valid,
           dn_ia_data, dn_ia_valid, dn_wt_data, dn_wt_valid, partial_c_in, out_ready,
    input  in_ready, out_valid, out_data, out_lane_valid, out_partial_c, cur_mode, occupancy
  );

  modport slave (
    input  mode_sparse, in_valid, ia_data, ia_valid, wt_data, wt_valid,
           dn_ia_data, dn_ia_valid, dn_wt_data, dn_wt_valid, partial_c_in, out_ready,
    output in_ready, out_valid, out_data, out_lane_valid, out_partial_c, cur_mode, occupancy
  );
endinterface

// File: rtl/mul_array_pipe.sv
// F x I signed full-precision multiplier array with per-mode pipeline latency,
// valid/ready backpressure that freezes the pipe, and a drain before any mode change.
module mul_array_pipe #(
  parameter int F          = 4,
  parameter int I          = 4,
  parameter int DW         = 16,
  parameter int PW         = 32,
  parameter int SPARSE_LAT = 6,
  parameter int DENSE_LAT  = 1
) (
  input logic              clk,
  input logic              rst,
  mul_array_pipe_if.slave  bus
);
  localparam int MAXLAT = (SPARSE_LAT > DENSE_LAT) ? SPARSE_LAT : DENSE_LAT;
  localparam int OCCW   = $clog2(MAXLAT + 1);
  localparam int IDXW   = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam int N      = F * I;
  localparam int OW     = N * PW;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              cur_mode_q, cur_mode_d;
  logic [OCCW-1:0]   occ_q, occ_d;
  logic [MAXLAT-1:0] vld_q;
  logic [MAXLAT-1:0] tag_q;
  logic [OW-1:0]     data_q [MAXLAT];
  logic [N-1:0]      lv_q   [MAXLAT];

  logic [OW-1:0]     prod;
  logic [N-1:0]      laneValid;
  int                latInt;
  logic [IDXW-1:0]   tap;
  logic [MAXLAT-1:0] liveMask;
  logic              outValid, stall, outHs, modeMatch, inReady, accept;

  // Operands follow the mode in effect; a beat is only accepted when the requested mode matches it.
  for (genvar n = 0; n < N; n++) begin : g_lane
    localparam int A = n / F;
    localparam int W = n % F;
    logic signed [DW-1:0] opA, opB;
    logic signed [PW-1:0] extA, extB;
    logic                 laneOk;

    assign opA    = cur_mode_q ? bus.ia_data[A*DW +: DW] : bus.dn_ia_data[n*DW +: DW];
    assign opB    = cur_mode_q ? bus.wt_data[W*DW +: DW] : bus.dn_wt_data;
    assign laneOk = cur_mode_q ? (bus.ia_valid[A] & bus.wt_valid[W])
                               : (bus.dn_ia_valid[n] & bus.dn_wt_valid);
    assign extA   = {{(PW-DW){opA[DW-1]}}, opA};
    assign extB   = {{(PW-DW){opB[DW-1]}}, opB};
    assign laneValid[n]      = laneOk;
    assign prod[n*PW +: PW]  = laneOk ? (extA * extB) : '0;
  end

  assign latInt    = cur_mode_q ? SPARSE_LAT : DENSE_LAT;
  assign tap       = IDXW'(latInt - 1);
  assign outValid  = vld_q[tap];
  assign stall     = outValid & ~bus.out_ready;
  assign outHs     = outValid & bus.out_ready;
  assign modeMatch = (bus.mode_sparse == cur_mode_q);
  assign accept    = bus.in_valid & inReady;

  // Stages at or beyond the active latency never hold a live beat, so stale beats cannot surface after a mode switch.
  always_comb begin
    liveMask = '0;
    for (int k = 0; k < MAXLAT; k++) liveMask[k] = (k < latInt);
  end

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    inReady    = 1'b0;
    case (state_q)
      RUN: begin
        if (!modeMatch) begin
          if (occ_q == '0) cur_mode_d = bus.mode_sparse;
          else             state_d    = DRAIN;
        end else begin
          inReady = ~stall;
        end
      end
      DRAIN: begin
        if (occ_q == '0) begin
          cur_mode_d = bus.mode_sparse;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (accept && !outHs)      occ_d = occ_q + 1'b1;
    else if (!accept && outHs) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cur_mode_q <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
      for (int k = 0; k < MAXLAT; k++) begin
        data_q[k] <= '0;
        lv_q[k]   <= '0;
      end
    end else if (!stall) begin
      vld_q[0]  <= accept;
      data_q[0] <= prod;
      lv_q[0]   <= laneValid;
      tag_q[0]  <= bus.partial_c_in;
      for (int k = 1; k < MAXLAT; k++) begin
        vld_q[k]  <= vld_q[k-1] & liveMask[k];
        data_q[k] <= data_q[k-1];
        lv_q[k]   <= lv_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
    end
  end

  assign bus.in_ready       = inReady;
  assign bus.out_valid      = outValid;
  assign bus.out_data       = outValid ? data_q[tap] : '0;
  assign bus.out_lane_valid = outValid ? lv_q[tap] : '0;
  assign bus.out_partial_c  = outValid & tag_q[tap];
  assign bus.cur_mode       = cur_mode_q;
  assign bus.occupancy      = occ_q;
endmodule
